// File: rtl/kernel_mem_ctrl.sv
// Sequencer for the banked kernel weight store: scatters a weight stream round-robin
// over the banks (LOAD) or sweeps all banks in lock-step and flags returning words (READ).
module kernel_mem_ctrl #(
   parameter int KERNEL_BRAM_NUM           = 4,
   parameter int KERNEL_BRAM_ADDRESS_WIDTH = 16,
   parameter int DATA_WIDTH                = 32,
   parameter int BRAM_READ_LATENCY         = 2
) (
   input  logic                                              i_clock,
   input  logic                                              i_reset,
   input  logic                                              i_load_start,
   input  logic                                              i_read_start,
   input  logic [KERNEL_BRAM_ADDRESS_WIDTH-1:0]              i_len,
   input  logic [DATA_WIDTH-1:0]                             i_s_data,
   input  logic                                              i_s_valid,
   output logic                                              o_s_ready,
   output logic [KERNEL_BRAM_NUM-1:0]                        o_enable,
   output logic [KERNEL_BRAM_NUM-1:0]                        o_wenable,
   output logic [KERNEL_BRAM_NUM*KERNEL_BRAM_ADDRESS_WIDTH-1:0] o_waddress,
   output logic [DATA_WIDTH-1:0]                             o_bram_data,
   output logic [KERNEL_BRAM_NUM-1:0]                        o_renable,
   output logic [KERNEL_BRAM_NUM*KERNEL_BRAM_ADDRESS_WIDTH-1:0] o_raddress,
   output logic                                              o_rd_valid,
   output logic                                              o_rd_last,
   output logic                                              o_busy,
   output logic                                              o_load_done,
   output logic                                              o_read_done
);

   localparam int N   = KERNEL_BRAM_NUM;
   localparam int AW  = KERNEL_BRAM_ADDRESS_WIDTH;
   localparam int DW  = DATA_WIDTH;
   localparam int LAT = BRAM_READ_LATENCY;
   localparam int BW  = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {IDLE, LOAD, READ, DRAIN} state_t;

   state_t          state_q, state_d;
   logic [AW-1:0]   len_q, len_d;
   logic [BW-1:0]   bank_q, bank_d;
   logic [AW-1:0]   wcnt_q, wcnt_d;
   logic            s_ready_q, s_ready_d;
   logic [N-1:0]    wen_q, wen_d;
   logic [AW-1:0]   waddr_q, waddr_d;
   logic [DW-1:0]   bdata_q, bdata_d;
   logic            ren_q, ren_d;
   logic [AW-1:0]   raddr_q, raddr_d;
   logic [LAT-1:0]  rvld_pipe_q, rvld_pipe_d;
   logic [LAT-1:0]  rlast_pipe_q, rlast_pipe_d;
   logic            load_done_q, load_done_d;
   logic            rzero_done_q, rzero_done_d;

   logic            last_raddr;
   logic            last_word;

   assign last_raddr = (raddr_q == len_q - AW'(1));
   // Word count N*len is tracked as (address, bank) so it never needs AW+log2(N) bits.
   assign last_word  = (bank_q == BW'(N - 1)) && (wcnt_q == len_q - AW'(1));

   always_comb begin
      state_d      = state_q;
      len_d        = len_q;
      bank_d       = bank_q;
      wcnt_d       = wcnt_q;
      s_ready_d    = s_ready_q;
      wen_d        = '0;
      waddr_d      = waddr_q;
      bdata_d      = bdata_q;
      ren_d        = ren_q;
      raddr_d      = raddr_q;
      load_done_d  = 1'b0;
      rzero_done_d = 1'b0;
      // Read-valid and last flags ride a shift register matching the BRAM latency.
      rvld_pipe_d  = (rvld_pipe_q << 1) | LAT'(ren_q);
      rlast_pipe_d = (rlast_pipe_q << 1) | LAT'(ren_q && last_raddr);

      case (state_q)
         IDLE: begin
            if (i_load_start) begin
               len_d  = i_len;
               bank_d = '0;
               wcnt_d = '0;
               if (i_len == '0) begin
                  load_done_d = 1'b1;
               end else begin
                  state_d   = LOAD;
                  s_ready_d = 1'b1;
               end
            end else if (i_read_start) begin
               len_d = i_len;
               if (i_len == '0) begin
                  rzero_done_d = 1'b1;
               end else begin
                  state_d = READ;
                  ren_d   = 1'b1;
                  raddr_d = '0;
               end
            end
         end
         LOAD: begin
            if (i_s_valid && s_ready_q) begin
               wen_d[bank_q] = 1'b1;
               waddr_d       = wcnt_q;
               bdata_d       = i_s_data;
               if (bank_q == BW'(N - 1)) begin
                  bank_d = '0;
                  wcnt_d = wcnt_q + AW'(1);
               end else begin
                  bank_d = bank_q + BW'(1);
               end
               if (last_word) begin
                  s_ready_d   = 1'b0;
                  load_done_d = 1'b1;
                  state_d     = IDLE;
               end
            end
         end
         READ: begin
            if (last_raddr) begin
               ren_d   = 1'b0;
               raddr_d = '0;
               state_d = DRAIN;
            end else begin
               raddr_d = raddr_q + AW'(1);
            end
         end
         DRAIN: begin
            if (rlast_pipe_q[LAT-1]) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         state_q      <= IDLE;
         len_q        <= '0;
         bank_q       <= '0;
         wcnt_q       <= '0;
         s_ready_q    <= 1'b0;
         wen_q        <= '0;
         waddr_q      <= '0;
         bdata_q      <= '0;
         ren_q        <= 1'b0;
         raddr_q      <= '0;
         rvld_pipe_q  <= '0;
         rlast_pipe_q <= '0;
         load_done_q  <= 1'b0;
         rzero_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         len_q        <= len_d;
         bank_q       <= bank_d;
         wcnt_q       <= wcnt_d;
         s_ready_q    <= s_ready_d;
         wen_q        <= wen_d;
         waddr_q      <= waddr_d;
         bdata_q      <= bdata_d;
         ren_q        <= ren_d;
         raddr_q      <= raddr_d;
         rvld_pipe_q  <= rvld_pipe_d;
         rlast_pipe_q <= rlast_pipe_d;
         load_done_q  <= load_done_d;
         rzero_done_q <= rzero_done_d;
      end
   end

   assign o_s_ready   = s_ready_q;
   assign o_enable    = wen_q;
   assign o_wenable   = wen_q;
   assign o_waddress  = {N{waddr_q}};
   assign o_bram_data = bdata_q;
   assign o_renable   = {N{ren_q}};
   assign o_raddress  = {N{raddr_q}};
   assign o_rd_valid  = rvld_pipe_q[LAT-1];
   assign o_rd_last   = rlast_pipe_q[LAT-1];
   assign o_busy      = (state_q != IDLE);
   assign o_load_done = load_done_q;
   // A zero-length read finishes without a sweep, so its done pulse bypasses the pipe.
   assign o_read_done = rlast_pipe_q[LAT-1] | rzero_done_q;

endmodule
